immed_unit: RTL and testbench
=============================

IMMED_UNIT -- requirements
Module: immed_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter PASS_W, default 8, width of an opaque sideband tag carried with each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state rises on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-007 SHALL have port in_inst  input  32  raw RV instruction word.
REQ-008 SHALL have port in_pc  input  XLEN  instruction address.
REQ-009 SHALL have port in_tag  input  PASS_W  sideband, forwarded unchanged.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_immed  output  XLEN  sign/zero-extended immediate.
REQ-013 SHALL have port out_target  output  XLEN  in_pc + out_immed, modulo 2^XLEN.
REQ-014 SHALL have port out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-015 SHALL have port out_tag  output  PASS_W  forwarded in_tag.

Function
REQ-016 Decode on in_inst[6:0]: LOAD/OP-IMM/JALR -> I {inst[31:20]}; STORE -> S {inst[31:25],inst[11:7]}; BRANCH -> B {inst[31],inst[7],inst[30:25],inst[11:8],0}; LUI/AUIPC -> U {inst[31:12],12'b0}; JAL -> J {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-017 I/S/B/J immediates SHALL be sign-extended from their MSB to XLEN; U SHALL be sign-extended from bit 31 (matters for XLEN=64).
REQ-018 Any other opcode SHALL yield out_immed=0, out_fmt=NONE, out_target=in_pc; no error raised.
REQ-019 Transfer occurs on a port when valid and ready are both high in the same cycle.
REQ-020 Stage SHALL be a 2-entry skid buffer: main output register plus one skid register; latency 1 cycle from input transfer to out_valid when not stalled.
REQ-021 in_ready SHALL be a registered signal equal to "skid register empty"; it SHALL not depend combinationally on out_ready.
REQ-022 Input accepted while out_valid=1 and out_ready=0 SHALL go to the skid register; in_ready falls the next cycle.
REQ-023 When the skid register is full and an output transfer occurs, skid contents SHALL move to the output register the same edge; in_ready rises next cycle.
REQ-024 Simultaneous input and output transfer with skid empty SHALL load the new result into the output register; out_valid stays 1.
REQ-025 Output transfer with no input and skid empty SHALL clear out_valid.
REQ-026 Ordering SHALL be strictly FIFO; no instruction dropped or duplicated.
REQ-027 Output data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 out_target SHALL be computed from the registered in_pc and immediate (adder before or after the register is an implementation choice, latency unchanged).

Reset
REQ-029 rst SHALL asynchronously clear out_valid=0, skid-valid=0, in_ready=1 on release, out_immed=0, out_target=0, out_fmt=NONE, out_tag=0.
REQ-030 rst asserted mid-stream SHALL discard both buffered entries; none appear after release.

Configuration
REQ-031 Macro IMMED_UNIT_CSR_ZIMM_EN: when defined, SYSTEM opcode (1110011) with funct3[2]=1 SHALL yield out_fmt=Z, out_immed = zero-extended inst[19:15], out_target=in_pc; when undefined, SYSTEM SHALL decode as NONE per REQ-018.

Verification
REQ-032 XLEN=32, in 0xFFF00093 (addi x1,x0,-1), pc 0x100, out_ready=1 -> next cycle out_immed 0xFFFFFFFF, fmt I, target 0x000000FF.
REQ-033 in 0xFE000EE3 (beq -4), pc 0x200 -> out_immed 0xFFFFFFFC, fmt B, target 0x1FC; 0x0080006F (jal +8) pc 0x200 -> immed 8, fmt J, target 0x208.
REQ-034 XLEN=64, in 0x80000037 (lui 0x80000) -> out_immed 0xFFFFFFFF80000000, fmt U.
REQ-035 Hold out_ready=0, present 3 back-to-back instructions tags 1,2,3 -> tags 1,2 buffered, in_ready=0 from cycle 2, tag 3 stalled; release out_ready -> tags 1,2,3 emerge in order, no gaps.
REQ-036 Assert rst with both entries full -> out_valid=0 immediately, in_ready=1 after release, no stale output; with IMMED_UNIT_CSR_ZIMM_EN, 0x3401D073 (csrrwi, zimm 3) -> immed 3, fmt Z; without it -> immed 0, fmt NONE.

Source files
------------

// File: rtl/immed_unit.sv
// immed_unit: RV immediate extraction stage with a 2-entry skid buffer.
// Decodes the immediate of the incoming instruction, computes pc + immediate,
// and forwards an opaque sideband tag. in_ready is purely registered
// (skid register empty), so upstream never sees a combinational path from
// out_ready.
// Optional feature: define IMMED_UNIT_CSR_ZIMM_EN to decode SYSTEM CSR*I
// instructions as format Z (zero-extended 5-bit zimm, target = pc).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | output register and skid register both empty
// ST_ONE   | output register valid, skid register empty
// ST_TWO   | output register valid, skid register holds next
module immed_unit #(
  parameter int XLEN   = 32,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [PASS_W-1:0] in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_immed,
  output logic [XLEN-1:0]   out_target,
  output logic [2:0]        out_fmt,
  output logic [PASS_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMMED_UNIT_CSR_ZIMM_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_load_out_in;
  logic              w_load_out_skid;
  logic              w_load_skid;

  logic [31:0]       w_imm32;
  logic [2:0]        w_fmt;
  logic              w_add_en;
  logic [XLEN-1:0]   w_immed;
  logic [XLEN-1:0]   w_target;

  logic [XLEN-1:0]   r_skid_immed;
  logic [XLEN-1:0]   r_skid_target;
  logic [2:0]        r_skid_fmt;
  logic [PASS_W-1:0] r_skid_tag;

  logic [XLEN-1:0]   r_out_immed;
  logic [XLEN-1:0]   r_out_target;
  logic [2:0]        r_out_fmt;
  logic [PASS_W-1:0] r_out_tag;

  // Immediate decode; every immediate fits a sign-extended 32-bit value.
  always_comb begin
    w_imm32  = '0;
    w_fmt    = FMT_NONE;
    w_add_en = 1'b0;
    case (in_inst[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        w_imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
        w_fmt    = FMT_I;
        w_add_en = 1'b1;
      end
      OP_STORE: begin
        w_imm32  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        w_fmt    = FMT_S;
        w_add_en = 1'b1;
      end
      OP_BRANCH: begin
        w_imm32  = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
        w_fmt    = FMT_B;
        w_add_en = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm32  = {in_inst[31:12], 12'b0};
        w_fmt    = FMT_U;
        w_add_en = 1'b1;
      end
      OP_JAL: begin
        w_imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};
        w_fmt    = FMT_J;
        w_add_en = 1'b1;
      end
`ifdef IMMED_UNIT_CSR_ZIMM_EN
      OP_SYSTEM: begin
        // zimm is an operand, not an offset, so the target stays at pc
        if (in_inst[14]) begin
          w_imm32 = {27'b0, in_inst[19:15]};
          w_fmt   = FMT_Z;
        end
      end
`endif
      default: begin
        w_imm32  = '0;
        w_fmt    = FMT_NONE;
        w_add_en = 1'b0;
      end
    endcase
  end

  // Widen to XLEN; bit 31 of the 32-bit value is the sign for every format.
  generate
    if (XLEN > 32) begin : g_wide
      assign w_immed = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_narrow
      assign w_immed = w_imm32;
    end
  endgenerate

  // Target adder sits ahead of the registers so both entries carry final data.
  always_comb begin
    w_target = in_pc;
    if (w_add_en) begin
      w_target = in_pc + w_immed;
    end
  end

  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and register load steering.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_load_out_in = 1'b1;
          w_state_nxt   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_out_in = 1'b1;
        end else if (w_in_xfer) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path is possible
        if (w_out_xfer) begin
          w_load_out_skid = 1'b1;
          w_state_nxt     = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Skid register: catches an accepted instruction while the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_immed  <= '0;
      r_skid_target <= '0;
      r_skid_fmt    <= FMT_NONE;
      r_skid_tag    <= '0;
    end else if (w_load_skid) begin
      r_skid_immed  <= w_immed;
      r_skid_target <= w_target;
      r_skid_fmt    <= w_fmt;
      r_skid_tag    <= in_tag;
    end
  end

  // Output register: loads fresh decode or the skid entry, else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_immed  <= '0;
      r_out_target <= '0;
      r_out_fmt    <= FMT_NONE;
      r_out_tag    <= '0;
    end else if (w_load_out_in) begin
      r_out_immed  <= w_immed;
      r_out_target <= w_target;
      r_out_fmt    <= w_fmt;
      r_out_tag    <= in_tag;
    end else if (w_load_out_skid) begin
      r_out_immed  <= r_skid_immed;
      r_out_target <= r_skid_target;
      r_out_fmt    <= r_skid_fmt;
      r_out_tag    <= r_skid_tag;
    end
  end

  assign out_immed  = r_out_immed;
  assign out_target = r_out_target;
  assign out_fmt    = r_out_fmt;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_immed_unit.sv
// Bench for immed_unit: a 32-bit and a 64-bit instance share one stimulus
// stream; a queue-based reference model predicts readiness, validity and
// the payload of every entry.
module tb_immed_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [63:0] in_pc64;
  logic [7:0]  in_tag;

  logic        in_ready,  in_ready64;
  logic        out_valid, out_valid64;
  logic [31:0] out_immed, out_target;
  logic [63:0] out_immed64, out_target64;
  logic [2:0]  out_fmt, out_fmt64;
  logic [7:0]  out_tag, out_tag64;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tgt32;
    logic [63:0] tgt64;
  } exp_t;

  exp_t q[$];

  immed_unit #(.XLEN(32), .PASS_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_immed(out_immed), .out_target(out_target),
    .out_fmt(out_fmt), .out_tag(out_tag)
  );

  immed_unit #(.XLEN(64), .PASS_W(8)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc64), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_immed(out_immed64), .out_target(out_target64),
    .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // Reference: field values assembled arithmetically, then sign-folded.
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc64,
                                 input logic [7:0] tag);
    exp_t   e;
    longint raw;
    int     bits;
    longint val;
    raw  = 0;
    bits = 0;
    e.fmt = 3'd0;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67: begin
        raw = longint'(inst[31:20]); bits = 12; e.fmt = 3'd1;
      end
      7'h23: begin
        raw = longint'(inst[31:25]) * 32 + longint'(inst[11:7]); bits = 12; e.fmt = 3'd2;
      end
      7'h63: begin
        raw = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
            + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
        bits = 13; e.fmt = 3'd3;
      end
      7'h37, 7'h17: begin
        raw = longint'(inst[31:12]) * 4096; bits = 32; e.fmt = 3'd4;
      end
      7'h6F: begin
        raw = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
            + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        bits = 21; e.fmt = 3'd5;
      end
      default: begin
        raw = 0; bits = 0; e.fmt = 3'd0;
      end
    endcase
    if (bits != 0 && raw >= (longint'(1) << (bits - 1)))
      val = raw - (longint'(1) << bits);
    else
      val = raw;
    e.imm   = val;
    e.tgt64 = pc64 + e.imm;
    e.tgt32 = pc64[31:0] + e.imm[31:0];
`ifdef IMMED_UNIT_CSR_ZIMM_EN
    if (inst[6:0] == 7'h73 && inst[14]) begin
      e.fmt   = 3'd6;
      e.imm   = 64'(inst[19:15]);
      e.tgt64 = pc64;
      e.tgt32 = pc64[31:0];
    end
`endif
    e.tag = tag;
    return e;
  endfunction

  task automatic check_outputs();
    exp_t h;
    chk("in_ready32", in_ready, q.size() < 2);
    chk("in_ready64", in_ready64, q.size() < 2);
    chk("out_valid32", out_valid, q.size() > 0);
    chk("out_valid64", out_valid64, q.size() > 0);
    if (q.size() > 0) begin
      h = q[0];
      chk("tag32", out_tag, h.tag);
      chk("tag64", out_tag64, h.tag);
      chk("fmt32", out_fmt, h.fmt);
      chk("fmt64", out_fmt64, h.fmt);
      chk("immed32", out_immed, h.imm[31:0]);
      chk("immed64", out_immed64, h.imm);
      chk("target32", out_target, h.tgt32);
      chk("target64", out_target64, h.tgt64);
    end
  endtask

  // Called at a negedge: check, drive, advance model, run one clock.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] pchi, input logic [7:0] tag, input logic ordy);
    logic in_fire;
    logic out_fire;
    check_outputs();
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    in_pc64   = {pchi, pc};
    in_tag    = tag;
    out_ready = ordy;
    in_fire  = v && (q.size() < 2);
    out_fire = ordy && (q.size() > 0);
    if (out_fire) void'(q.pop_front());
    if (in_fire) q.push_back(model(inst, {pchi, pc}, tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [10];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
    w = $urandom();
    w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 8'h0, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_pc64 = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_immed", out_immed, 32'h0);
    chk("rst_target", out_target, 32'h0);
    chk("rst_fmt", out_fmt, 3'd0);
    chk("rst_tag", out_tag, 8'h0);
    rst = 1'b0;
    @(negedge clk);

    // addi x1,x0,-1 at pc 0x100
    cycle(1'b1, 32'hFFF00093, 32'h100, 32'h0, 8'h11, 1'b1);
    chk("addi_immed", out_immed, 32'hFFFFFFFF);
    chk("addi_fmt", out_fmt, 3'd1);
    chk("addi_target", out_target, 32'h000000FF);
    // beq -4 at pc 0x200
    cycle(1'b1, 32'hFE000EE3, 32'h200, 32'h0, 8'h12, 1'b1);
    chk("beq_immed", out_immed, 32'hFFFFFFFC);
    chk("beq_fmt", out_fmt, 3'd3);
    chk("beq_target", out_target, 32'h1FC);
    // jal +8 at pc 0x200
    cycle(1'b1, 32'h0080006F, 32'h200, 32'h0, 8'h13, 1'b1);
    chk("jal_immed", out_immed, 32'h8);
    chk("jal_fmt", out_fmt, 3'd5);
    chk("jal_target", out_target, 32'h208);
    // lui 0x80000 on the 64-bit instance
    cycle(1'b1, 32'h80000037, 32'h400, 32'h0, 8'h14, 1'b1);
    chk("lui64_immed", out_immed64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", out_fmt64, 3'd4);
    // csrrwi with zimm 3
    cycle(1'b1, 32'h3401D073, 32'h300, 32'h0, 8'h15, 1'b1);
`ifdef IMMED_UNIT_CSR_ZIMM_EN
    chk("csr_immed", out_immed, 32'h3);
    chk("csr_fmt", out_fmt, 3'd6);
`else
    chk("csr_immed", out_immed, 32'h0);
    chk("csr_fmt", out_fmt, 3'd0);
`endif
    chk("csr_target", out_target, 32'h300);
    drain();

    // Back-to-back under stall: tags 1,2 buffered, tag 3 held off.
    cycle(1'b1, rand_inst(), 32'h1000, 32'h0, 8'd1, 1'b0);
    cycle(1'b1, rand_inst(), 32'h1004, 32'h0, 8'd2, 1'b0);
    chk("stall_in_ready", in_ready, 1'b0);
    cycle(1'b1, 32'h00100093, 32'h1008, 32'h0, 8'd3, 1'b0);
    chk("stall_hold_tag", out_tag, 8'd1);
    chk("stall_in_ready2", in_ready, 1'b0);
    cycle(1'b1, 32'h00100093, 32'h1008, 32'h0, 8'd3, 1'b1);
    chk("release_tag2", out_tag, 8'd2);
    cycle(1'b1, 32'h00100093, 32'h1008, 32'h0, 8'd3, 1'b1);
    chk("release_tag3", out_tag, 8'd3);
    chk("release_valid", out_valid, 1'b1);
    drain();

    // Reset with both entries full.
    cycle(1'b1, rand_inst(), $urandom(), $urandom(), 8'hA1, 1'b0);
    cycle(1'b1, rand_inst(), $urandom(), $urandom(), 8'hA2, 1'b0);
    check_outputs();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid32", out_valid, 1'b0);
    chk("midrst_valid64", out_valid64, 1'b0);
    chk("midrst_immed", out_immed, 32'h0);
    chk("midrst_tag", out_tag, 8'h0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom(), $urandom(),
            8'($urandom()), $urandom_range(0, 9) < 6);
    end
    drain();
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
